// File: rtl/tile_window_pipe_pkg.sv
// Shared sizing helpers and default geometry for the tile window pipeline.
// Widths derived here keep the top, sub-module and interface in agreement.
package tile_window_pkg;

   function automatic int calcPicW(input int numPics);
      return (numPics <= 2) ? 1 : $clog2(numPics);
   endfunction

   function automatic int calcCntW(input int frames);
      return (frames <= 2) ? 1 : $clog2(frames);
   endfunction

   function automatic int calcExtent(input int tiles, input int sizeLog2);
      return tiles << sizeLog2;
   endfunction

   localparam int DEF_TILE_W_LOG2 = 8;
   localparam int DEF_TILE_H_LOG2 = 7;
   localparam int DEF_TILES_X     = 2;
   localparam int DEF_TILES_Y     = 3;
   localparam int DEF_NUM_PICS    = DEF_TILES_X * DEF_TILES_Y;
   localparam int DEF_PIC_W       = calcPicW(DEF_NUM_PICS);
   localparam int DEF_GRID_W      = calcExtent(DEF_TILES_X, DEF_TILE_W_LOG2);
   localparam int DEF_GRID_H      = calcExtent(DEF_TILES_Y, DEF_TILE_H_LOG2);

endpackage

// File: rtl/tile_window_pipe_if.sv
// Pixel-side bus of the tile window pipeline: raster/origin controls in,
// decoded window results out.
interface tile_window_pipe_if #(
   parameter int COORD_W = 10,
   parameter int PIC_W   = 3,
   parameter int ADDR_W  = 15
) ();

   logic               pix_en;
   logic [COORD_W-1:0] r;
   logic [COORD_W-1:0] c;
   logic [COORD_W-1:0] org_r;
   logic [COORD_W-1:0] org_c;
   logic               org_load;
   logic               scroll_en;
   logic               valid_out;
   logic               mask;
   logic [PIC_W-1:0]   which_pic;
   logic [ADDR_W-1:0]  addr;
   logic [2:0]         rgb_en;
   logic               tile_row_done;
   logic               frame_done;

   modport master (
      output pix_en, r, c, org_r, org_c, org_load, scroll_en,
      input  valid_out, mask, which_pic, addr, rgb_en, tile_row_done, frame_done
   );

   modport slave (
      input  pix_en, r, c, org_r, org_c, org_load, scroll_en,
      output valid_out, mask, which_pic, addr, rgb_en, tile_row_done, frame_done
   );

endinterface

// File: rtl/tile_window_pipe_scroll_ctrl.sv
// Frame-synchronous state: shadow/active grid origin and the picture
// rotation counter that advances every SCROLL_FRAMES frames.
module scroll_ctrl
   import tile_window_pkg::*;
#(
   parameter int COORD_W       = 10,
   parameter int SCROLL_FRAMES = 60,
   parameter int NUM_PICS      = DEF_NUM_PICS,
   parameter int PIC_W         = DEF_PIC_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_frameStart,
   input  logic               i_frameDone,
   input  logic               i_scrollEn,
   input  logic               i_orgLoad,
   input  logic [COORD_W-1:0] i_orgR,
   input  logic [COORD_W-1:0] i_orgC,
   output logic [COORD_W-1:0] o_actOrgR,
   output logic [COORD_W-1:0] o_actOrgC,
   output logic [PIC_W-1:0]   o_scrollOff
);

   localparam int CNT_W = calcCntW(SCROLL_FRAMES);

   logic [COORD_W-1:0] r_shadowR;
   logic [COORD_W-1:0] r_shadowC;
   logic [COORD_W-1:0] r_actR;
   logic [COORD_W-1:0] r_actC;
   logic [CNT_W-1:0]   r_frameCnt;
   logic [PIC_W-1:0]   r_scrollOff;

   // Frame start copies the old shadow; a same-cycle load overwrites the shadow afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shadowR <= '0;
         r_shadowC <= '0;
         r_actR    <= '0;
         r_actC    <= '0;
      end else begin
         if (i_frameStart) begin
            r_actR <= r_shadowR;
            r_actC <= r_shadowC;
         end
         if (i_orgLoad) begin
            r_shadowR <= i_orgR;
            r_shadowC <= i_orgC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_frameCnt  <= '0;
         r_scrollOff <= '0;
      end else if (!i_scrollEn) begin
         r_frameCnt <= '0;
      end else if (i_frameDone) begin
         if (r_frameCnt == CNT_W'(SCROLL_FRAMES - 1)) begin
            r_frameCnt  <= '0;
            r_scrollOff <= (r_scrollOff == PIC_W'(NUM_PICS - 1)) ? '0 : r_scrollOff + PIC_W'(1);
         end else begin
            r_frameCnt <= r_frameCnt + CNT_W'(1);
         end
      end
   end

   assign o_actOrgR   = r_actR;
   assign o_actOrgC   = r_actC;
   assign o_scrollOff = r_scrollOff;

endmodule

// File: rtl/tile_window_pipe.sv
// Two-stage raster-to-tile decoder: stage 0 captures the pixel, stage 1
// resolves grid membership, picture index, in-tile address and events.
module tile_window_pipe
   import tile_window_pkg::*;
#(
   parameter int TILE_W_LOG2   = 8,
   parameter int TILE_H_LOG2   = 7,
   parameter int TILES_X       = 2,
   parameter int TILES_Y       = 3,
   parameter int COORD_W       = 10,
   parameter int H_LAST        = 799,
   parameter int V_LAST        = 524,
   parameter int SCROLL_FRAMES = 60
) (
   input  logic             clk,
   input  logic             reset,
   tile_window_pipe_if.slave io_px
);

   localparam int NUM_PICS = TILES_X * TILES_Y;
   localparam int PIC_W    = calcPicW(NUM_PICS);
   localparam int ADDR_W   = TILE_H_LOG2 + TILE_W_LOG2;
   localparam int GRID_H   = calcExtent(TILES_Y, TILE_H_LOG2);
   localparam int GRID_W   = calcExtent(TILES_X, TILE_W_LOG2);

   logic               r_s0Valid;
   logic [COORD_W-1:0] r_s0Row;
   logic [COORD_W-1:0] r_s0Col;
   logic [COORD_W-1:0] w_actOrgR;
   logic [COORD_W-1:0] w_actOrgC;
   logic [PIC_W-1:0]   w_scrollOff;
   logic               w_frameStart;
   logic               w_frameDone;
   logic signed [COORD_W:0] w_relR;
   logic signed [COORD_W:0] w_relC;
   logic               w_rowIn;
   logic               w_colIn;
   logic               w_mask;
   logic               w_rowDone;
   int                 w_tileY;
   int                 w_tileX;
   int                 w_picSum;
   logic [PIC_W-1:0]   w_pic;
   logic [ADDR_W-1:0]  w_addr;

   assign w_frameStart = io_px.pix_en && (io_px.r == '0) && (io_px.c == '0);

   scroll_ctrl #(
      .COORD_W      (COORD_W),
      .SCROLL_FRAMES(SCROLL_FRAMES),
      .NUM_PICS     (NUM_PICS),
      .PIC_W        (PIC_W)
   ) u_scrollCtrl (
      .clk         (clk),
      .reset       (reset),
      .i_frameStart(w_frameStart),
      .i_frameDone (w_frameDone),
      .i_scrollEn  (io_px.scroll_en),
      .i_orgLoad   (io_px.org_load),
      .i_orgR      (io_px.org_r),
      .i_orgC      (io_px.org_c),
      .o_actOrgR   (w_actOrgR),
      .o_actOrgC   (w_actOrgC),
      .o_scrollOff (w_scrollOff)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s0Valid <= 1'b0;
         r_s0Row   <= '0;
         r_s0Col   <= '0;
      end else begin
         r_s0Valid <= io_px.pix_en;
         if (io_px.pix_en) begin
            r_s0Row <= io_px.r;
            r_s0Col <= io_px.c;
         end
      end
   end

   // The extra sign bit keeps pixels left of / above the origin out of the grid.
   always_comb begin
      w_relR   = $signed({1'b0, r_s0Row}) - $signed({1'b0, w_actOrgR});
      w_relC   = $signed({1'b0, r_s0Col}) - $signed({1'b0, w_actOrgC});
      w_rowIn  = !w_relR[COORD_W] && (int'(w_relR[COORD_W-1:0]) < GRID_H);
      w_colIn  = !w_relC[COORD_W] && (int'(w_relC[COORD_W-1:0]) < GRID_W);
      w_mask   = r_s0Valid && w_rowIn && w_colIn;
      w_tileY  = int'(w_relR[COORD_W-1:0]) >> TILE_H_LOG2;
      w_tileX  = int'(w_relC[COORD_W-1:0]) >> TILE_W_LOG2;
      w_picSum = w_tileY * TILES_X + w_tileX + int'(w_scrollOff);
      if (w_picSum >= NUM_PICS) begin
         w_picSum = w_picSum - NUM_PICS;
      end
      w_pic    = w_mask ? PIC_W'(w_picSum) : '0;
      w_addr   = w_mask ? {w_relR[TILE_H_LOG2-1:0], w_relC[TILE_W_LOG2-1:0]} : '0;
      w_rowDone = r_s0Valid && w_rowIn && (&w_relR[TILE_H_LOG2-1:0])
                  && !w_relC[COORD_W] && (int'(w_relC[COORD_W-1:0]) == GRID_W);
      w_frameDone = r_s0Valid && (r_s0Row == COORD_W'(V_LAST)) && (r_s0Col == COORD_W'(H_LAST));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         io_px.valid_out     <= 1'b0;
         io_px.mask          <= 1'b0;
         io_px.which_pic     <= '0;
         io_px.addr          <= '0;
         io_px.rgb_en        <= '0;
         io_px.tile_row_done <= 1'b0;
         io_px.frame_done    <= 1'b0;
      end else begin
         io_px.valid_out     <= r_s0Valid;
         io_px.mask          <= w_mask;
         io_px.which_pic     <= w_pic;
         io_px.addr          <= w_addr;
         io_px.rgb_en        <= {3{w_mask}};
         io_px.tile_row_done <= w_rowDone;
         io_px.frame_done    <= w_frameDone;
      end
   end

endmodule

// File: tb/tb_tile_window_pipe.sv
// Directed bench for tile_window_pipe: geometry, events, latency, scrolling,
// origin staging and mid-frame reset, all against hand-computed values.
module tb_tile_window_pipe;

   logic clk;
   logic reset;
   int   nChecks;
   int   nErrors;

   tile_window_pipe_if #(.COORD_W(10), .PIC_W(3), .ADDR_W(15)) px ();

   tile_window_pipe #(.SCROLL_FRAMES(2)) dut (
      .clk  (clk),
      .reset(reset),
      .io_px(px)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      nChecks++;
      if (observed != expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // One pixel per call; returns on the negedge where its results are visible.
   task automatic applyStimulus(input int row, input int col);
      @(negedge clk);
      px.pix_en = 1'b1;
      px.r      = 10'(row);
      px.c      = 10'(col);
      @(negedge clk);
      px.pix_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic checkPixel(input string tag, input int expMask, input int expPic, input int expAddr);
      checkOutput({tag, "_valid"}, int'(px.valid_out), 1);
      checkOutput({tag, "_mask"}, int'(px.mask), expMask);
      checkOutput({tag, "_pic"}, int'(px.which_pic), expPic);
      checkOutput({tag, "_addr"}, int'(px.addr), expAddr);
      checkOutput({tag, "_rgb"}, int'(px.rgb_en), expMask ? 7 : 0);
   endtask

   task automatic loadOrigin(input int row, input int col);
      @(negedge clk);
      px.org_r    = 10'(row);
      px.org_c    = 10'(col);
      px.org_load = 1'b1;
      @(negedge clk);
      px.org_load = 1'b0;
   endtask

   initial begin
      nChecks      = 0;
      nErrors      = 0;
      reset        = 1'b1;
      px.pix_en    = 1'b1;
      px.r         = 10'd130;
      px.c         = 10'd300;
      px.org_r     = '0;
      px.org_c     = '0;
      px.org_load  = 1'b0;
      px.scroll_en = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_valid", int'(px.valid_out), 0);
      checkOutput("rst_mask", int'(px.mask), 0);
      checkOutput("rst_rgb", int'(px.rgb_en), 0);
      px.r = 10'd524;
      px.c = 10'd799;
      @(negedge clk);
      checkOutput("rst_frame_done", int'(px.frame_done), 0);
      px.pix_en = 1'b0;
      reset     = 1'b0;

      // Default origin 0, no scrolling
      applyStimulus(130, 300);
      checkPixel("t11", 1, 3, (2 << 8) | 44);
      applyStimulus(384, 0);
      checkPixel("r384", 0, 0, 0);
      applyStimulus(127, 511);
      checkPixel("lastcol", 1, 1, 32767);
      checkOutput("trd_early", int'(px.tile_row_done), 0);
      applyStimulus(127, 512);
      checkOutput("trd_pulse", int'(px.tile_row_done), 1);
      checkOutput("trd_mask", int'(px.mask), 0);
      applyStimulus(126, 512);
      checkOutput("trd_notlast", int'(px.tile_row_done), 0);
      applyStimulus(524, 799);
      checkOutput("fd_pulse", int'(px.frame_done), 1);
      @(negedge clk);
      checkOutput("fd_width", int'(px.frame_done), 0);
      applyStimulus(524, 798);
      checkOutput("fd_neighbour", int'(px.frame_done), 0);

      // Latency: valid_out appears exactly two clocks after pix_en
      @(negedge clk);
      px.pix_en = 1'b1;
      px.r      = 10'd1;
      px.c      = 10'd1;
      @(negedge clk);
      px.pix_en = 1'b0;
      checkOutput("lat_1clk", int'(px.valid_out), 0);
      @(negedge clk);
      checkOutput("lat_2clk", int'(px.valid_out), 1);
      @(negedge clk);
      checkOutput("lat_drop", int'(px.valid_out), 0);

      // Scroll every 2 frames over 6 pictures
      px.scroll_en = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         applyStimulus(524, 799);
         applyStimulus(0, 0);
         checkOutput($sformatf("scroll_%0d", k), int'(px.which_pic), (k / 2) % 6);
      end
      px.scroll_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(524, 799);
      end
      applyStimulus(0, 0);
      checkOutput("scroll_hold", int'(px.which_pic), 1);
      applyStimulus(130, 300);
      checkOutput("scroll_hold_t11", int'(px.which_pic), 4);

      // Mid-line reset with a staged origin
      loadOrigin(200, 200);
      @(negedge clk);
      px.pix_en = 1'b1;
      px.r      = 10'd300;
      px.c      = 10'd300;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rstmid_valid", int'(px.valid_out), 0);
      checkOutput("rstmid_mask", int'(px.mask), 0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rel_1clk", int'(px.valid_out), 0);
      @(negedge clk);
      px.pix_en = 1'b0;
      checkOutput("rel_2clk", int'(px.valid_out), 1);
      checkOutput("rel_pic", int'(px.which_pic), 5);
      applyStimulus(0, 0);
      checkPixel("rst_org0", 1, 0, 0);
      applyStimulus(10, 10);
      checkOutput("rst_org0_b", int'(px.mask), 1);

      // Origin staging: last load wins, current frame unaffected
      loadOrigin(300, 300);
      loadOrigin(50, 100);
      applyStimulus(10, 10);
      checkOutput("org_cur_mask", int'(px.mask), 1);
      applyStimulus(50, 100);
      checkOutput("org_cur_addr", int'(px.addr), (50 << 8) | 100);
      applyStimulus(524, 799);
      @(negedge clk);
      px.pix_en   = 1'b1;
      px.r        = '0;
      px.c        = '0;
      px.org_r    = 10'd5;
      px.org_c    = 10'd5;
      px.org_load = 1'b1;
      @(negedge clk);
      px.pix_en   = 1'b0;
      px.org_load = 1'b0;
      @(negedge clk);
      checkOutput("org_neg_mask", int'(px.mask), 0);
      applyStimulus(50, 100);
      checkPixel("org_corner", 1, 0, 0);
      applyStimulus(49, 100);
      checkOutput("org_above", int'(px.mask), 0);
      applyStimulus(50, 99);
      checkOutput("org_left", int'(px.mask), 0);
      applyStimulus(433, 611);
      checkPixel("org_far", 1, 5, 32767);
      applyStimulus(434, 100);
      checkOutput("org_below", int'(px.mask), 0);
      applyStimulus(177, 612);
      checkOutput("org_trd", int'(px.tile_row_done), 1);
      applyStimulus(524, 799);
      applyStimulus(0, 0);
      checkOutput("org_next_neg", int'(px.mask), 0);
      applyStimulus(5, 5);
      checkPixel("org_next", 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
